// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker: EX operand bypass selects plus load-use / no-forward stall for the in-order pipe.
// Define FWD_PERF_CNT_EN to build the saturating stall and forward counters.
module fwd_hazard_tracker #(
  parameter int REG_AW = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH = 2,
  localparam int SELW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fw_en,
  input  logic                      adv,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_mem_rd,
  output logic [NUM_SRC*SELW-1:0]   sel,
  output logic                      hazard_stall,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               fwd_cnt
);
  logic [DEPTH:0] vld_q, vld_d, wb_q, wb_d, mr_q, mr_d;
  logic [DEPTH:0][REG_AW-1:0] dest_q, dest_d;
  logic [NUM_SRC*REG_AW-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] sv_q, sv_d;
  logic cap;
  // Scanning oldest to youngest lets the youngest matching producer overwrite older ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = DEPTH; k >= 1; k--)
        if (fw_en && vld_q[k] && wb_q[k] && sv_q[i] && dest_q[k] == src_q[i*REG_AW +: REG_AW])
          sel[i*SELW +: SELW] = SELW'(k);
  end
  // Stage DEPTH writes the register file on the falling edge, so it never stalls ID.
  always_comb begin
    hazard_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < DEPTH; k++)
        if (id_valid && id_src_vld[i] && vld_q[k] && wb_q[k] &&
            dest_q[k] == id_src[i*REG_AW +: REG_AW] && (fw_en ? (k == 0 && mr_q[0]) : 1'b1))
          hazard_stall = 1'b1;
  end
  assign cap    = id_valid & ~hazard_stall & ~flush;
  assign vld_d  = adv ? {vld_q[DEPTH-1:0], cap} : vld_q;
  assign wb_d   = adv ? {wb_q[DEPTH-1:0], cap & id_wb_en} : wb_q;
  assign mr_d   = adv ? {mr_q[DEPTH-1:0], cap & id_mem_rd} : mr_q;
  assign dest_d = adv ? {dest_q[DEPTH-1:0], id_dest} : dest_q;
  assign src_d  = adv ? id_src : src_q;
  assign sv_d   = adv ? (cap ? id_src_vld : '0) : sv_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wb_q   <= '0;
      mr_q   <= '0;
      dest_q <= '0;
      src_q  <= '0;
      sv_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      wb_q   <= wb_d;
      mr_q   <= mr_d;
      dest_q <= dest_d;
      src_q  <= src_d;
      sv_q   <= sv_d;
    end
  end
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, fwd_q, fwd_d;
  logic [32:0] fsum;
  always_comb begin
    fsum = {1'b0, fwd_q};
    for (int i = 0; i < NUM_SRC; i++)
      fsum = fsum + 33'(sel[i*SELW +: SELW] != '0);
    stall_d = (hazard_stall && adv && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    fwd_d   = !(adv && vld_q[0]) ? fwd_q : fsum[32] ? '1 : fsum[31:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else begin
      stall_q <= stall_d;
      fwd_q   <= fwd_d;
    end
  end
  assign stall_cnt = stall_q;
  assign fwd_cnt   = fwd_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif
endmodule

// File: doc/fwd_hazard_tracker.md
# fwd_hazard_tracker

Parametrised operand-forwarding and hazard-detection unit for the in-order pipeline, sitting beside the ID/EX/MEM/WB registers. It keeps its own shift-register copy of in-flight destination registers, so the pipeline only feeds it the ID-stage instruction and an advance strobe. It drives per-source bypass selects for the EX operand muxes and a load-use/no-forward stall to the ID stage. Source count, register-address width and forwarding depth are all configurable.

## Interface
- REG_AW, 4, register address width
- NUM_SRC, 2, source operands per instruction
- DEPTH, 2, producer stages after EX (1 = MEM … DEPTH = WB); must be ≥ 2
- SELW (local), $clog2(DEPTH+1), width of one select

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fw_en  in  1  forwarding enable
- adv  in  1  pipeline advances this cycle; 0 = whole pipe frozen
- flush  in  1  squash the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  ID source addresses, source i at [i*REG_AW +: REG_AW]
- id_src_vld  in  NUM_SRC  per-source read valid
- id_dest  in  REG_AW  ID destination
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_rd  in  1  ID instruction is a load
- sel  out  NUM_SRC*SELW  EX bypass select per source: 0 = register-file value, k = stage k result
- hazard_stall  out  1  hold ID/IF, insert bubble into EX
- stall_cnt  out  32  stall cycles (see Configuration)
- fwd_cnt  out  32  forwarded operands (see Configuration)

## Operation
- Tracker: entries 0..DEPTH, each {vld, wb_en, mem_rd, dest}. Entry 0 = EX. Also an EX source register {src, src_vld} per source.
- On clk with adv=1:
  - entry[k] <= entry[k-1], k = 1..DEPTH.
  - Entry 0 and EX sources <= ID fields if id_valid & ~hazard_stall & ~flush; otherwise bubble (all vld/wb_en/mem_rd/src_vld = 0).
- adv=0: all state holds. flush takes priority over ID capture. hazard_stall still evaluates.
- Producer k (1..DEPTH) matches EX source i when entry[k].vld & entry[k].wb_en & src_vld[i] & dest == src[i].
- sel[i]: fw_en=0 gives 0. Otherwise it is the smallest matching k (youngest wins), or 0 if none. Combinational from registered state only.
- hazard_stall, with ID source i valid (id_valid & id_src_vld[i]):
  - fw_en=1: asserted if entry 0 is vld & wb_en & mem_rd and its dest equals any valid ID source (load-use).
  - fw_en=0: asserted if any entry 0..DEPTH-1 is vld & wb_en with dest equal to any valid ID source. The register file writes stage DEPTH on the falling edge, so entry DEPTH never stalls.
- Invariant: a sel of 1 never points at an entry with mem_rd=1. The load-use stall guarantees this.

## Timing
- Reset (async assert, sync release): all entries and EX sources invalid; sel=0, hazard_stall=0, counters 0.
- sel and hazard_stall are combinational, with zero-cycle latency from state and ID inputs.
- Load-use costs exactly one bubble with fw_en=1. Dependent instructions cost up to DEPTH bubbles with fw_en=0.
- fw_en changes take effect the same cycle and do not alter tracker contents.
- Same-dest producers in several stages: the youngest wins. A source with src_vld=0 never matches, whatever its address.

## Configuration
- FWD_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with hazard_stall & adv.
  - fwd_cnt increments by the number of sources with nonzero sel on each adv cycle where entry 0 is vld.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: no counter flops; stall_cnt and fwd_cnt tied to 0.

## Test plan
- Reset: rst_n=0 mid-stream with entries valid -> sel=0 and hazard_stall=0 immediately; after release, tracker is empty.
- Adjacent dependency: ADD R1 then SUB using R1 as src0, fw_en=1, adv=1 -> sel0=1 when SUB is in EX; sel0=2 if a NOP sits between them.
- Youngest wins: R3 written by two consecutive instructions, consumer reads R3 as src1 -> sel1=1, not 2.
- Load-use: LDR R2, then ADD reading R2 -> hazard_stall=1 for exactly one cycle, bubble in EX, then sel=2; stall_cnt=1 with FWD_PERF_CNT_EN.
- fw_en=0: ADD R1 then consumer of R1 -> hazard_stall held 2 cycles, all sel=0 throughout.
- Freeze and flush: adv=0 for 3 cycles -> sel and tracker unchanged. flush=1 with adv=1 -> entry 0 becomes a bubble, and the next cycle a dependent consumer sees no forward from it.
